misr_response_compactor: RTL and testbench

- Multiple-input signature register (MISR) that compacts per-cycle response words from a circuit under test built from the generic cell library (BUF/INV/AND/…/DFF).
- Sits directly downstream of the circuit under test. Its output is one signature compared against a golden value.
- Provides a start/busy/done handshake for the simulation bench or BIST controller.

---
 rtl/misr_response_compactor.sv | 69 ++++++
 tb/tb_misr_response_compactor.sv | 94 +++++++++
 2 files changed

// File: rtl/misr_response_compactor.sv
// misr_response_compactor: MISR that compacts response words into a signature and checks it against a golden value
module misr_response_compactor #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = 16'h002D,
  parameter logic [WIDTH-1:0] SEED = '0,
  parameter int PATTERNS = 256,
  parameter int CNT_W = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [WIDTH-1:0] EXPECTED,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [WIDTH-1:0] SIGNATURE,
  output logic [CNT_W-1:0] COUNT
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, done_q, pass_q, last;
  always_comb begin
    sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ IN_DATA;
    cnt_d = cnt_q + CNT_W'(1);
    last  = cnt_q == CNT_W'(PATTERNS - 1);
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      sig_q   <= SEED;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (START) begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
          sig_q   <= SEED;
          cnt_q   <= '0;
        end
        S_RUN: if (IN_VALID) begin
          sig_q <= sig_d;
          cnt_q <= cnt_d;
          if (last) begin
            // pass judges the signature including the word accepted on this edge
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= sig_d == EXPECTED;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign SIGNATURE = sig_q;
  assign COUNT     = cnt_q;
endmodule

// File: tb/tb_misr_response_compactor.sv
// tb_misr_response_compactor: directed scoreboard bench for two small MISR configurations (2 and 3 words per run)
module tb_misr_response_compactor;
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1, START = 1'b0, IN_VALID = 1'b0;
  logic [3:0] IN_DATA = '0, exp2 = 4'hB, exp3 = 4'h0;
  logic       busy2, done2, pass2, busy3, done3, pass3;
  logic [3:0] sig2, sig3;
  logic [7:0] cnt2, cnt3;
  int n_cmp = 0, n_bad = 0;

  typedef struct packed {
    logic       sel;
    logic [3:0] sig;
    logic [7:0] cnt;
    logic       busy, done, pass;
  } exp_t;
  exp_t  exp_q[$];
  string tag_q[$];

  always #5 CLOCK = ~CLOCK;

  misr_response_compactor #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .PATTERNS(2), .CNT_W(8)) u2 (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .EXPECTED(exp2), .BUSY(busy2), .DONE(done2), .PASS(pass2), .SIGNATURE(sig2), .COUNT(cnt2));
  misr_response_compactor #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .PATTERNS(3), .CNT_W(8)) u3 (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .EXPECTED(exp3), .BUSY(busy3), .DONE(done3), .PASS(pass3), .SIGNATURE(sig3), .COUNT(cnt3));

  task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  // sel=0 observes the 2-word instance, sel=1 the 3-word instance
  task automatic cyc(input string tag, input logic sel, input logic rs, input logic st, input logic v,
                     input logic [3:0] d, input logic [3:0] es, input logic [7:0] ec,
                     input logic eb, input logic ed, input logic ep);
    exp_t e;
    string t;
    RESET = rs; START = st; IN_VALID = v; IN_DATA = d;
    e.sel = sel; e.sig = es; e.cnt = ec; e.busy = eb; e.done = ed; e.pass = ep;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLOCK);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, "sig",  {4'h0, e.sel ? sig3 : sig2}, {4'h0, e.sig});
    chk(t, "cnt",  e.sel ? cnt3 : cnt2, e.cnt);
    chk(t, "busy", {7'h0, e.sel ? busy3 : busy2}, {7'h0, e.busy});
    chk(t, "done", {7'h0, e.sel ? done3 : done2}, {7'h0, e.done});
    chk(t, "pass", {7'h0, e.sel ? pass3 : pass2}, {7'h0, e.pass});
  endtask

  initial begin
    cyc("rst_a",    0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
    cyc("rst_b",    0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
    cyc("rst_c",    1, 1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
    cyc("idle_v",   0, 0, 0, 1, 4'h8, 4'h0, 0, 0, 0, 0);
    cyc("fb_start", 0, 0, 1, 0, 4'h0, 4'h0, 0, 1, 0, 0);
    cyc("fb_w1",    0, 0, 0, 1, 4'h8, 4'h8, 1, 1, 0, 0);
    cyc("fb_w2",    0, 0, 0, 1, 4'h8, 4'hB, 2, 0, 1, 1);
    cyc("done_v",   0, 0, 0, 1, 4'h5, 4'hB, 2, 0, 1, 1);
    exp2 = 4'h0;
    cyc("exp_chg",  0, 0, 0, 0, 4'h0, 4'hB, 2, 0, 1, 1);
    exp2 = 4'hB;
    cyc("gap_rst",  1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
    cyc("gap_st",   1, 0, 1, 0, 4'h0, 4'h0, 0, 1, 0, 0);
    cyc("gap_1",    1, 0, 0, 1, 4'h1, 4'h1, 1, 1, 0, 0);
    cyc("gap_2",    1, 0, 0, 0, 4'h1, 4'h1, 1, 1, 0, 0);
    cyc("gap_3",    1, 0, 0, 0, 4'h1, 4'h1, 1, 1, 0, 0);
    cyc("gap_4",    1, 0, 0, 1, 4'h1, 4'h3, 2, 1, 0, 0);
    cyc("gap_5",    1, 0, 0, 0, 4'h1, 4'h3, 2, 1, 0, 0);
    cyc("gap_6",    1, 0, 0, 1, 4'h1, 4'h7, 3, 0, 1, 0);
    cyc("gap_hold", 1, 0, 0, 1, 4'h1, 4'h7, 3, 0, 1, 0);
    cyc("ign_rst",  0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
    cyc("ign_st",   0, 0, 1, 0, 4'h0, 4'h0, 0, 1, 0, 0);
    cyc("ign_w1",   0, 0, 0, 1, 4'h8, 4'h8, 1, 1, 0, 0);
    cyc("ign_pls",  0, 0, 1, 0, 4'h0, 4'h8, 1, 1, 0, 0);
    cyc("ign_w2",   0, 0, 0, 1, 4'h8, 4'hB, 2, 0, 1, 1);
    cyc("restart",  0, 0, 1, 1, 4'h8, 4'h0, 0, 1, 0, 0);
    cyc("mid_w1",   0, 0, 0, 1, 4'h8, 4'h8, 1, 1, 0, 0);
    cyc("mid_rst",  0, 1, 1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
    cyc("mid_idle", 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
    cyc("mid_st",   0, 0, 1, 0, 4'h0, 4'h0, 0, 1, 0, 0);
    cyc("mid_w1b",  0, 0, 0, 1, 4'h8, 4'h8, 1, 1, 0, 0);
    cyc("mid_w2b",  0, 0, 0, 1, 4'h8, 4'hB, 2, 0, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
